// File: rtl/demultiplexer_1_2_stream.sv
// 1-to-2 stream demultiplexer: each input word is steered by s0 into one of two
// independent 2-deep FIFOs, so a stalled output never blocks the other one.
module demultiplexer_1_2_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i0,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic             s0,
  output logic [WIDTH-1:0] f0,
  output logic [WIDTH-1:0] f1,
  output logic             f0_valid,
  output logic             f1_valid,
  input  logic             f0_ready,
  input  logic             f1_ready,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]       state [2];
  logic [WIDTH-1:0] head  [2];
  logic [WIDTH-1:0] tail  [2];
  logic [7:0]       cnt   [2];
  logic [1:0]       push;
  logic [1:0]       pop;

  // Ready looks only at the selected FIFO's fill level, never at downstream ready.
  assign i_ready = !rst && (s0 ? (state[1] != FULL) : (state[0] != FULL));

  always_comb begin
    push    = 2'b00;
    pop     = 2'b00;
    push[0] = i_valid && i_ready && !s0;
    push[1] = i_valid && i_ready && s0;
    pop[0]  = (state[0] != EMPTY) && f0_ready;
    pop[1]  = (state[1] != EMPTY) && f1_ready;
  end

  // Control: occupancy and acceptance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 2; n++) begin
        state[n] <= EMPTY;
        cnt[n]   <= 8'd0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        case (state[n])
          EMPTY:   if (push[n]) state[n] <= ONE;
          ONE: begin
            if (push[n] && !pop[n])      state[n] <= FULL;
            else if (pop[n] && !push[n]) state[n] <= EMPTY;
          end
          FULL:    if (pop[n]) state[n] <= ONE;
          default: state[n] <= EMPTY;
        endcase
        if (push[n]) cnt[n] <= cnt[n] + 8'd1;
      end
    end
  end

  // Data: head is the oldest word, tail only holds the second word when FULL
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      case (state[n])
        EMPTY: if (push[n]) head[n] <= i0;
        ONE: begin
          if (push[n] && pop[n]) head[n] <= i0;
          else if (push[n])      tail[n] <= i0;
        end
        FULL:  if (pop[n]) head[n] <= tail[n];
        default: ;
      endcase
    end
  end

  // Outputs are masked to zero when empty, which also covers immediate reset clearing
  assign f0_valid = (state[0] != EMPTY);
  assign f1_valid = (state[1] != EMPTY);
  assign f0       = f0_valid ? head[0] : '0;
  assign f1       = f1_valid ? head[1] : '0;
  assign cnt0     = cnt[0];
  assign cnt1     = cnt[1];

endmodule

// File: tb/tb_demultiplexer_1_2_stream.sv
// Randomized and directed bench for demultiplexer_1_2_stream; a queue-per-output
// reference model is checked by a negedge monitor.
module tb_demultiplexer_1_2_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i0 = 8'h00;
  logic       i_valid = 1'b0;
  logic       i_ready;
  logic       s0 = 1'b0;
  logic [7:0] f0, f1;
  logic       f0_valid, f1_valid;
  logic       f0_ready = 1'b0;
  logic       f1_ready = 1'b0;
  logic [7:0] cnt0, cnt1;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] mcnt0 = 8'd0;
  logic [7:0] mcnt1 = 8'd0;

  demultiplexer_1_2_stream #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .i0(i0), .i_valid(i_valid), .i_ready(i_ready), .s0(s0),
    .f0(f0), .f1(f1), .f0_valid(f0_valid), .f1_valid(f1_valid),
    .f0_ready(f0_ready), .f1_ready(f1_ready), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    q0.delete();
    q1.delete();
    mcnt0 = 8'd0;
    mcnt1 = 8'd0;
  endtask

  // Monitor: compare against the queue model, then apply this cycle's transfers to it.
  always @(negedge clk) begin
    logic exp_ready;
    logic do_push;
    exp_ready = !rst && (s0 ? (q1.size() < 2) : (q0.size() < 2));
    chk("i_ready", i_ready, exp_ready);
    chk("f0_valid", f0_valid, q0.size() > 0);
    chk("f1_valid", f1_valid, q1.size() > 0);
    chk("f0", f0, (q0.size() > 0) ? q0[0] : 8'h00);
    chk("f1", f1, (q1.size() > 0) ? q1[0] : 8'h00);
    chk("cnt0", cnt0, mcnt0);
    chk("cnt1", cnt1, mcnt1);
    if (!rst) begin
      do_push = i_valid && exp_ready;
      if (q0.size() > 0 && f0_ready) void'(q0.pop_front());
      if (q1.size() > 0 && f1_ready) void'(q1.pop_front());
      if (do_push) begin
        if (s0) begin
          q1.push_back(i0);
          mcnt1 = mcnt1 + 8'd1;
        end else begin
          q0.push_back(i0);
          mcnt0 = mcnt0 + 8'd1;
        end
      end
    end
  end

  initial begin
    // Power-up reset
    #2;
    chk("rst_f0_valid", f0_valid, 1'b0);
    chk("rst_i_ready", i_ready, 1'b0);
    cyc();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", i_ready, 1'b1);

    // Steering
    i_valid = 1'b1; s0 = 1'b0; i0 = 8'h11;
    cyc();
    chk("steer_f0", f0, 8'h11);
    chk("steer_cnt0", cnt0, 8'd1);
    s0 = 1'b1; i0 = 8'h22;
    cyc();
    chk("steer_f1", f1, 8'h22);
    chk("steer_cnt1", cnt1, 8'd1);
    chk("steer_f0_hold", f0, 8'h11);

    // Fill both FIFOs, then reset asynchronously mid-cycle
    s0 = 1'b0; i0 = 8'hA1;
    cyc();
    s0 = 1'b1; i0 = 8'hB1;
    cyc();
    i_valid = 1'b1;
    chk("both_full_rdy_s1", i_ready, 1'b0);
    s0 = 1'b0;
    #1;
    chk("both_full_rdy_s0", i_ready, 1'b0);
    rst = 1'b1;
    model_clear();
    #1;
    chk("arst_f0_valid", f0_valid, 1'b0);
    chk("arst_f1_valid", f1_valid, 1'b0);
    chk("arst_f0", f0, 8'h00);
    chk("arst_cnt0", cnt0, 8'd0);
    chk("arst_cnt1", cnt1, 8'd0);
    chk("arst_i_ready", i_ready, 1'b0);
    i_valid = 1'b0;
    cyc();
    rst = 1'b0;

    // Fill FIFO 0 and show FIFO 1 is unaffected
    i_valid = 1'b1; s0 = 1'b0; i0 = 8'hA1;
    cyc();
    i0 = 8'hA2;
    cyc();
    chk("fill_rdy_s0", i_ready, 1'b0);
    s0 = 1'b1; i0 = 8'hB1;
    #1;
    chk("iso_rdy_s1", i_ready, 1'b1);
    cyc();
    chk("iso_f1", f1, 8'hB1);
    chk("iso_f0_hold", f0, 8'hA1);
    i_valid = 1'b0;

    // Push and pop in ONE state
    rst = 1'b1; model_clear();
    cyc();
    rst = 1'b0;
    i_valid = 1'b1; s0 = 1'b0; i0 = 8'hA1;
    cyc();
    f0_ready = 1'b1; i0 = 8'hA2;
    cyc();
    chk("stream_f0", f0, 8'hA2);
    chk("stream_valid", f0_valid, 1'b1);
    i_valid = 1'b0;
    cyc();
    chk("stream_drain_valid", f0_valid, 1'b0);
    chk("stream_drain_f0", f0, 8'h00);

    // Counter wrap through output 1
    rst = 1'b1; model_clear();
    cyc();
    rst = 1'b0;
    f1_ready = 1'b1; s0 = 1'b1; i_valid = 1'b1;
    for (int k = 0; k < 256; k++) begin
      i0 = 8'(k);
      cyc();
    end
    i_valid = 1'b0;
    chk("wrap_cnt1", cnt1, 8'd0);
    chk("wrap_cnt0", cnt0, 8'd0);
    cyc();
    chk("wrap_drained", f1_valid, 1'b0);

    // Random traffic with one mid-run reset
    for (int c = 0; c < 3000; c++) begin
      i_valid  = ($urandom_range(0, 3) != 0);
      s0       = 1'($urandom_range(0, 1));
      i0       = 8'($urandom);
      f0_ready = ($urandom_range(0, 2) != 0);
      f1_ready = ($urandom_range(0, 3) == 0);
      if (c == 1500) begin
        rst = 1'b1;
        model_clear();
      end else begin
        rst = 1'b0;
      end
      cyc();
    end
    rst = 1'b0;

    // Drain with a bounded wait
    i_valid = 1'b0; f0_ready = 1'b1; f1_ready = 1'b1;
    for (int w = 0; w < 10 && (q0.size() > 0 || q1.size() > 0); w++) cyc();
    cyc();
    chk("drain_q0_empty", q0.size(), 0);
    chk("drain_q1_empty", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demultiplexer_1_2_stream.md
DEMULTIPLEXER_1_2_STREAM -- requirements
Module: demultiplexer_1_2_stream

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data word width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port i0, input, WIDTH bits: input data word.
REQ-005 The block SHALL have port i_valid, input, 1 bit: i0 holds a valid word.
REQ-006 The block SHALL have port i_ready, output, 1 bit: block accepts the word this cycle.
REQ-007 The block SHALL have port s0, input, 1 bit: destination select (0 to output 0, 1 to output 1), qualified by i_valid.
REQ-008 The block SHALL have ports f0 and f1, outputs, WIDTH bits each: head-of-queue data for outputs 0 and 1.
REQ-009 The block SHALL have ports f0_valid and f1_valid, outputs, 1 bit each: fN holds a valid word.
REQ-010 The block SHALL have ports f0_ready and f1_ready, inputs, 1 bit each: the downstream consumer takes the word.
REQ-011 The block SHALL have ports cnt0 and cnt1, outputs, 8 bits each: count of words accepted for each output.

Function
REQ-012 An input transfer SHALL occur on a rising clk edge when i_valid and i_ready are both 1; s0 SHALL be sampled on that same edge.
REQ-013 An output N transfer SHALL occur on a rising clk edge when fN_valid and fN_ready are both 1.
REQ-014 Each output SHALL own an independent 2-entry FIFO with states EMPTY (0 words), ONE (1 word) and FULL (2 words).
REQ-015 i_ready SHALL be 0 while rst is 1; otherwise it SHALL be the inverse of the FULL flag of the FIFO selected by the current s0.
REQ-016 i_ready SHALL depend on FIFO state and s0 only, with no combinational path from f0_ready or f1_ready.
REQ-017 The FIFO state SHALL change as follows:
- push only: EMPTY to ONE, ONE to FULL;
- pop only: FULL to ONE, ONE to EMPTY;
- push and pop together in ONE: stays ONE;
- no push or pop: unchanged.
REQ-018 A push into a FULL FIFO SHALL never occur, because i_ready is 0 in that case.
REQ-019 fN_valid SHALL be 1 exactly when FIFO N is not EMPTY, and fN SHALL show the oldest stored word.
REQ-020 Words SHALL leave each output in the same order they were accepted for that output, and none SHALL be lost or duplicated.
REQ-021 Latency: a word accepted into an EMPTY FIFO at edge k SHALL appear on fN with fN_valid=1 immediately after edge k.
REQ-022 A push and a pop in the same cycle SHALL move the next word to the head of the queue and place the new word behind it, with no bubble.
REQ-023 fN SHALL hold its value while fN_valid=1 and fN_ready=0.
REQ-024 fN SHALL be 0 whenever FIFO N is EMPTY.
REQ-025 Traffic to one output SHALL never be stalled by the other output:
- a FULL FIFO 1 SHALL not block transfers with s0=0;
- a FULL FIFO 0 SHALL not block transfers with s0=1.
REQ-026 A change of s0 while i_valid=1 and i_ready=0 SHALL re-evaluate i_ready against the newly selected FIFO in the same cycle.
REQ-027 cntN SHALL increment by 1 on each input transfer with s0=N, and SHALL wrap from 255 to 0.
REQ-028 When i_valid=0, no FIFO state and no counter SHALL change because of i0 or s0.

Reset
REQ-029 Asserting rst SHALL immediately, without waiting for a clock edge, set:
- both FIFOs to EMPTY;
- f0_valid, f1_valid, f0 and f1 to 0;
- cnt0 and cnt1 to 0.
REQ-030 Asserting rst mid-operation SHALL discard all stored words; no output transfer SHALL occur on any edge while rst is 1.
REQ-031 After rst deasserts, the first rising edge SHALL be able to accept a word (i_ready=1).

Verification
REQ-032 The bench SHALL cover reset: assert rst with both FIFOs FULL -> f0_valid=f1_valid=0, cnt0=cnt1=0 and i_ready=0, all before the next clk edge.
REQ-033 The bench SHALL cover steering: send 0x11 with s0=0, then 0x22 with s0=1 -> f0=0x11 and f1=0x22 one cycle after each transfer, cnt0=1, cnt1=1.
REQ-034 The bench SHALL cover fill and isolation: hold f0_ready=0 and send 0xA1, 0xA2 with s0=0 -> FIFO 0 FULL, i_ready=0 for s0=0; then send 0xB1 with s0=1 -> accepted at once.
REQ-035 The bench SHALL cover order and streaming: with FIFO 0 in ONE holding 0xA1, push 0xA2 while popping -> f0 becomes 0xA2 next cycle, state stays ONE, no bubble.
REQ-036 The bench SHALL cover counter wrap: 256 transfers with s0=1 and f1_ready=1 -> cnt1 returns to 0 and all 256 words are seen in order on f1.
